// File: rtl/arb_pkg.sv
// Shared types and constants for the I-cache/D-cache memory port arbiter.
package arb_pkg;

   localparam int DEF_ADDR_W = 28;
   localparam int DEF_DATA_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } arb_state_t;

   localparam logic REQ_IC = 1'b0;
   localparam logic REQ_DC = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: req[0] is the I-cache, req[1] the D-cache.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       valid,
   output logic       winner
);

   // On a tie the requester that did not win last time goes next
   always_comb begin
      valid = |req;
      if (&req) begin
         winner = ~last;
      end else begin
         winner = req[1];
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one off-chip memory port between the I-cache and D-cache engines.
// Optional watchdog on stalled memory transactions: define ARB_TIMEOUT_EN.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ic_req_i,
   input  logic              ic_wen_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   input  logic [DATA_W-1:0] ic_wdata_i,
   output logic [DATA_W-1:0] ic_rdata_o,
   output logic              ic_ack_o,
   input  logic              dc_req_i,
   input  logic              dc_wen_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic [DATA_W-1:0] dc_wdata_i,
   output logic [DATA_W-1:0] dc_rdata_o,
   output logic              dc_ack_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              grant_sel_o,
   output logic              busy_o,
   output logic              err_o
);

   arb_state_t        state;
   logic              last_grant;
   logic              pick_valid;
   logic              pick_winner;
   logic              win_wen;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic [DATA_W-1:0] done_data;
   logic              timeout;

`ifdef ARB_TIMEOUT_EN
   localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);
   logic [9:0] to_cnt;

   assign timeout = (to_cnt == TO_LAST);
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   rr_pick2 u_pick (
      .req    ({dc_req_i, ic_req_i}),
      .last   (last_grant),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   // Steer the winning requester's command onto the latch inputs
   always_comb begin
      if (pick_winner == REQ_DC) begin
         win_wen   = dc_wen_i;
         win_addr  = dc_addr_i;
         win_wdata = dc_wdata_i;
      end else begin
         win_wen   = ic_wen_i;
         win_addr  = ic_addr_i;
         win_wdata = ic_wdata_i;
      end
   end

   // A watchdog expiry returns zero data instead of the bus value
   always_comb begin
      if (mem_ready_i) begin
         done_data = mem_rdata_i;
      end else begin
         done_data = '0;
      end
   end

   // Arbitration FSM; every output it drives is a register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         last_grant  <= REQ_IC;
         grant_sel_o <= REQ_IC;
         busy_o      <= 1'b0;
         mem_read_o  <= 1'b0;
         mem_write_o <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         ic_rdata_o  <= '0;
         dc_rdata_o  <= '0;
         ic_ack_o    <= 1'b0;
         dc_ack_o    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         to_cnt      <= 10'd0;
         err_o       <= 1'b0;
`endif
      end else begin
         ic_ack_o <= 1'b0;
         dc_ack_o <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         err_o    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state       <= BUSY;
                  busy_o      <= 1'b1;
                  grant_sel_o <= pick_winner;
                  last_grant  <= pick_winner;
                  mem_addr_o  <= win_addr;
                  mem_wdata_o <= win_wdata;
                  mem_read_o  <= ~win_wen;
                  mem_write_o <= win_wen;
`ifdef ARB_TIMEOUT_EN
                  to_cnt      <= 10'd0;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               if (mem_ready_i || timeout) begin
                  state       <= ACK;
                  mem_read_o  <= 1'b0;
                  mem_write_o <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                  err_o       <= ~mem_ready_i;
`endif
                  if (grant_sel_o == REQ_DC) begin
                     dc_rdata_o <= done_data;
                     dc_ack_o   <= 1'b1;
                  end else begin
                     ic_rdata_o <= done_data;
                     ic_ack_o   <= 1'b1;
                  end
               end else begin
                  state <= BUSY;
`ifdef ARB_TIMEOUT_EN
                  to_cnt <= to_cnt + 10'd1;
`endif
               end
            end
            ACK: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               busy_o      <= 1'b0;
               mem_read_o  <= 1'b0;
               mem_write_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
